xfer_sequencer: RTL and testbench
=================================

XFER_SEQUENCER -- requirements
Module: xfer_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 255: number of RX_WAIT cycles before a response timeout.
REQ-002 The block SHALL have parameter MAX_TRIES, default 3: total transmit attempts (first attempt plus retries) per request.
REQ-003 The block SHALL have these ports; reset is asynchronous and active-low.
- clk  in  1  single clock
- rst_b  in  1  asynchronous active-low reset
- req_valid  in  1  protocol FSM requests a transfer
- req_pkt  in  99  packet to send
- req_expect_resp  in  1  a response packet is expected
- req_ready  out  1  sequencer idle; request accepted when req_valid && req_ready
- done  out  1  one-cycle completion pulse
- status  out  2  result valid with done: 0=OK, 1=TIMEOUT, 2=CRC_ERR
- resp_pkt  out  99  captured response; valid with done when status=OK and a response was expected
- dp_pkt_in  out  99  packet to datapath encoder
- dp_pkt_in_avail  out  1  one-cycle launch strobe to encoder
- dp_encoder_ready  in  1  encoder idle
- dp_re  out  1  receive enable to bus driver
- dp_pkt_out  in  99  decoded packet
- dp_pkt_out_avail  in  1  decoded packet strobe
- dp_data_good  in  1  CRC check result, qualified by dp_pkt_out_avail
- dp_decoder_ready  in  1  decoder idle

Function
REQ-004 The block SHALL implement states IDLE, LAUNCH, TX_BUSY, TX_DRAIN, RX_ARM, RX_WAIT and FINISH.
REQ-005 In IDLE, req_ready SHALL be 1; on accept, the block SHALL latch req_pkt and req_expect_resp, clear the try counter to 1, and go to LAUNCH.
REQ-006 LAUNCH SHALL hold until dp_encoder_ready=1, then assert dp_pkt_in_avail for exactly one cycle with dp_pkt_in equal to the latched packet, and go to TX_BUSY.
REQ-007 dp_pkt_in SHALL be held stable from LAUNCH until the block leaves TX_DRAIN.
REQ-008 TX_BUSY SHALL wait for dp_encoder_ready=0, then go to TX_DRAIN.
REQ-009 TX_DRAIN SHALL wait for dp_encoder_ready=1; it SHALL then go to RX_ARM if a response is expected, else to FINISH with status OK.
REQ-010 RX_ARM SHALL wait for dp_decoder_ready=1, assert dp_re, clear the timer, and go to RX_WAIT.
REQ-011 dp_re SHALL be 1 only in RX_ARM (after the condition is met) and in RX_WAIT; it SHALL never be 1 while the encoder is launched or draining.
REQ-012 In RX_WAIT, the timer SHALL increment each cycle.
REQ-013 In RX_WAIT, dp_pkt_out_avail with dp_data_good=1 SHALL capture dp_pkt_out into resp_pkt and go to FINISH with status OK.
REQ-014 In RX_WAIT, dp_pkt_out_avail with dp_data_good=0 SHALL be a CRC failure.
REQ-015 In RX_WAIT, timer reaching TIMEOUT_CYC-1 without a packet SHALL be a timeout failure.
REQ-016 If a packet strobe and timer expiry occur in the same cycle, the packet SHALL take priority.
REQ-017 On a failure with try counter < MAX_TRIES, the block SHALL increment the counter, deassert dp_re, and go to LAUNCH to retransmit the latched packet.
REQ-018 On a failure with try counter = MAX_TRIES, the block SHALL go to FINISH with status TIMEOUT or CRC_ERR, per the last failure.
REQ-019 FINISH SHALL assert done for one cycle with a stable status, then return to IDLE.
REQ-020 req_ready SHALL be 0 in FINISH, so no request is accepted in the done cycle.
REQ-021 req_valid while not in IDLE SHALL be ignored.
REQ-022 dp_pkt_out_avail outside RX_WAIT SHALL be ignored.
REQ-023 The timer SHALL be ceil(log2(TIMEOUT_CYC+1)) bits wide and SHALL saturate, never wrap.
REQ-024 The try counter SHALL be ceil(log2(MAX_TRIES+1)) bits wide.

Reset
REQ-025 On rst_b=0, the block SHALL enter IDLE asynchronously at any time, including mid-transfer, and drop any pending request without a done pulse.
REQ-026 Reset values SHALL be: req_ready=1, done=0, status=0, resp_pkt=0, dp_pkt_in=0, dp_pkt_in_avail=0, dp_re=0, timer=0, try counter=0.

Structure
REQ-027 Shared package usb_pkg SHALL hold PKT_W=99, the status enum (OK, TIMEOUT, CRC_ERR) and the sequencer state enum.
REQ-028 One sub-module, xfer_timer (clear, enable, saturating count, expire flag), SHALL implement the response timeout.

Verification
REQ-029 The bench SHALL cover a no-response send: req_expect_resp=0 with encoder_ready toggling 1->0 (5 cycles)->1 -> exactly one avail pulse, dp_re never 1, done with status=0.
REQ-030 The bench SHALL cover a good response: expect_resp=1, dp_pkt_out=99'h1A5 with data_good=1 at RX_WAIT cycle 10 -> resp_pkt=99'h1A5, status=0, one launch.
REQ-031 The bench SHALL cover retry recovery: CRC failure on tries 1 and 2, good packet on try 3 -> exactly 3 avail pulses, status=0.
REQ-032 The bench SHALL cover timeout exhaustion: no response with TIMEOUT_CYC=255 -> 3 launches, each RX_WAIT lasting 255 cycles, then status=1.
REQ-033 The bench SHALL cover a simultaneous event: good packet arriving on the same cycle as timer expiry -> status=0, no retry.
REQ-034 The bench SHALL cover reset mid-operation: rst_b=0 during TX_DRAIN -> all outputs at reset values immediately, no done pulse, req_ready=1 after release.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared types for the transfer sequencer: packet width, result codes, FSM states.
package usb_pkg;

    localparam int unsigned PKT_W = 99;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_CRC_ERR = 2'd2
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LAUNCH   = 3'd1,
        S_TX_BUSY  = 3'd2,
        S_TX_DRAIN = 3'd3,
        S_RX_ARM   = 3'd4,
        S_RX_WAIT  = 3'd5,
        S_FINISH   = 3'd6
    } seq_state_e;

    typedef struct packed {
        logic [PKT_W-1:0] pkt;
        logic             expect_resp;
    } xfer_req_t;

endpackage

// File: rtl/xfer_timer.sv
// Saturating response timer; expire_o is high while the count sits at LIMIT-1 or above.
module xfer_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             expire_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Expire is registered alongside the count so it always reflects count_q.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count_q  <= '0;
            expire_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            expire_q <= (count_d >= CNT_EXP);
        end
    end

    assign expire_o = expire_q;

endmodule

// File: rtl/xfer_sequencer.sv
// Transfer sequencer: launches a packet to the encoder, optionally awaits a
// response from the decoder, and retries on CRC error or timeout.
module xfer_sequencer
    import usb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned MAX_TRIES   = 3
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             req_valid,
    input  logic [PKT_W-1:0] req_pkt,
    input  logic             req_expect_resp,
    output logic             req_ready,
    output logic             done,
    output logic [1:0]       status,
    output logic [PKT_W-1:0] resp_pkt,
    output logic [PKT_W-1:0] dp_pkt_in,
    output logic             dp_pkt_in_avail,
    input  logic             dp_encoder_ready,
    output logic             dp_re,
    input  logic [PKT_W-1:0] dp_pkt_out,
    input  logic             dp_pkt_out_avail,
    input  logic             dp_data_good,
    input  logic             dp_decoder_ready
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);

    seq_state_e       state_q, state_d;
    xfer_req_t        req_q, req_d;
    logic [TRY_W-1:0] try_q, try_d;
    status_e          status_q, status_d;
    logic [PKT_W-1:0] resp_q, resp_d;
    logic [PKT_W-1:0] pkt_in_q, pkt_in_d;
    logic             req_ready_q, req_ready_d;
    logic             done_q, done_d;
    logic             avail_q, avail_d;
    logic             re_q, re_d;
    logic             tmr_clear, tmr_enable, tmr_expire;
    logic             rx_good_c, rx_fail_c;
    status_e          fail_status_c;

    // A strobe always wins over a simultaneous timer expiry.
    assign rx_good_c     = (state_q == S_RX_WAIT) && dp_pkt_out_avail && dp_data_good;
    assign rx_fail_c     = (state_q == S_RX_WAIT) &&
                           ((dp_pkt_out_avail && !dp_data_good) || (!dp_pkt_out_avail && tmr_expire));
    assign fail_status_c = dp_pkt_out_avail ? ST_CRC_ERR : ST_TIMEOUT;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (req_valid) state_d = S_LAUNCH;
            S_LAUNCH:   if (dp_encoder_ready) state_d = S_TX_BUSY;
            S_TX_BUSY:  if (!dp_encoder_ready) state_d = S_TX_DRAIN;
            S_TX_DRAIN: if (dp_encoder_ready) state_d = req_q.expect_resp ? S_RX_ARM : S_FINISH;
            S_RX_ARM:   if (dp_decoder_ready) state_d = S_RX_WAIT;
            S_RX_WAIT: begin
                if (rx_good_c) begin
                    state_d = S_FINISH;
                end else if (rx_fail_c) begin
                    state_d = (try_q < TRY_MAX) ? S_LAUNCH : S_FINISH;
                end
            end
            S_FINISH:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath, derived from the transition taken.
    always_comb begin
        req_d       = req_q;
        try_d       = try_q;
        status_d    = status_q;
        resp_d      = resp_q;
        pkt_in_d    = pkt_in_q;
        req_ready_d = (state_d == S_IDLE);
        done_d      = (state_d == S_FINISH);
        avail_d     = (state_q == S_LAUNCH) && (state_d == S_TX_BUSY);
        re_d        = (state_d == S_RX_WAIT);
        tmr_clear   = (state_q == S_RX_ARM) && (state_d == S_RX_WAIT);
        tmr_enable  = (state_q == S_RX_WAIT);
        case (state_q)
            S_IDLE: begin
                if (state_d == S_LAUNCH) begin
                    req_d.pkt         = req_pkt;
                    req_d.expect_resp = req_expect_resp;
                    try_d             = TRY_W'(1);
                    pkt_in_d          = req_pkt;
                end
            end
            S_TX_DRAIN: begin
                if (state_d == S_FINISH) status_d = ST_OK;
            end
            S_RX_WAIT: begin
                if (rx_good_c) begin
                    resp_d   = dp_pkt_out;
                    status_d = ST_OK;
                end else if (rx_fail_c) begin
                    if (state_d == S_LAUNCH) begin
                        try_d    = try_q + TRY_W'(1);
                        pkt_in_d = req_q.pkt;
                    end else begin
                        status_d = fail_status_c;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            req_q       <= '0;
            try_q       <= '0;
            status_q    <= ST_OK;
            resp_q      <= '0;
            pkt_in_q    <= '0;
            req_ready_q <= 1'b1;
            done_q      <= 1'b0;
            avail_q     <= 1'b0;
            re_q        <= 1'b0;
        end else begin
            req_q       <= req_d;
            try_q       <= try_d;
            status_q    <= status_d;
            resp_q      <= resp_d;
            pkt_in_q    <= pkt_in_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            avail_q     <= avail_d;
            re_q        <= re_d;
        end
    end

    xfer_timer #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .rst_b    (rst_b),
        .clear_i  (tmr_clear),
        .enable_i (tmr_enable),
        .expire_o (tmr_expire)
    );

    assign req_ready       = req_ready_q;
    assign done            = done_q;
    assign status          = status_q;
    assign resp_pkt        = resp_q;
    assign dp_pkt_in       = pkt_in_q;
    assign dp_pkt_in_avail = avail_q;
    assign dp_re           = re_q;

endmodule

// File: tb/tb_xfer_sequencer.sv
// Directed bench for xfer_sequencer with encoder/decoder responders and a transaction model.
module tb_xfer_sequencer;
    import usb_pkg::*;

    localparam int TMO   = 255;
    localparam int TRIES = 3;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        req_valid, req_expect_resp, req_ready, done;
    logic [98:0] req_pkt, resp_pkt, dp_pkt_in, dp_pkt_out;
    logic [1:0]  status;
    logic        dp_pkt_in_avail, dp_encoder_ready, dp_re;
    logic        dp_pkt_out_avail, dp_data_good, dp_decoder_ready;

    xfer_sequencer #(.TIMEOUT_CYC(TMO), .MAX_TRIES(TRIES)) dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_pkt(req_pkt), .req_expect_resp(req_expect_resp),
        .req_ready(req_ready), .done(done), .status(status), .resp_pkt(resp_pkt),
        .dp_pkt_in(dp_pkt_in), .dp_pkt_in_avail(dp_pkt_in_avail),
        .dp_encoder_ready(dp_encoder_ready), .dp_re(dp_re),
        .dp_pkt_out(dp_pkt_out), .dp_pkt_out_avail(dp_pkt_out_avail),
        .dp_data_good(dp_data_good), .dp_decoder_ready(dp_decoder_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response plan per try: kind 0 = silent, 1 = bad CRC, 2 = good; delay in RX_WAIT cycles.
    int          plan_kind [3];
    int          plan_dly  [3];
    logic [98:0] plan_pkt;
    int          plan_base;

    logic [98:0] exp_pkt, exp_resp;
    int          exp_status;
    logic        exp_resp_valid;

    int n_avail = 0;
    int n_done  = 0;
    int n_rx    = 0;
    int run_len = 0;
    int runs[$];

    // Outcome of a request from the retry rules alone.
    function automatic void model(input logic exp_r, input int k0, input int k1, input int k2,
                                  output int st, output int tries);
        int k[3];
        k[0] = k0; k[1] = k1; k[2] = k2;
        st = 0;
        tries = 1;
        if (!exp_r) return;
        for (int i = 0; i < TRIES; i++) begin
            tries = i + 1;
            if (k[i] == 2) begin
                st = 0;
                return;
            end
            st = (k[i] == 1) ? 2 : 1;
        end
    endfunction

    // Encoder: drops ready for 5 cycles after each launch strobe.
    initial begin
        dp_encoder_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (dp_pkt_in_avail) begin
                dp_encoder_ready = 1'b0;
                repeat (5) @(negedge clk);
                dp_encoder_ready = 1'b1;
            end
        end
    end

    // Decoder: answers each receive window according to the plan.
    initial begin
        int  cur, rx_k;
        logic re_prev;
        cur = 0; rx_k = 0; re_prev = 1'b0;
        dp_pkt_out_avail = 1'b0; dp_data_good = 1'b0; dp_pkt_out = '0; dp_decoder_ready = 1'b1;
        forever begin
            @(negedge clk);
            dp_pkt_out_avail = 1'b0;
            dp_data_good     = 1'b0;
            if (dp_re) begin
                if (!re_prev) begin
                    cur = n_rx - plan_base;
                    n_rx++;
                    rx_k = 0;
                end else begin
                    rx_k++;
                end
                if (cur >= 0 && cur < 3 && plan_kind[cur] != 0 && rx_k == plan_dly[cur]) begin
                    dp_pkt_out_avail = 1'b1;
                    dp_data_good     = (plan_kind[cur] == 2);
                    dp_pkt_out       = (plan_kind[cur] == 2) ? plan_pkt : 99'h0BAD;
                end
            end
            re_prev = dp_re;
        end
    end

    // Per-cycle compare against the expectations of the current transaction.
    initial begin
        forever begin
            @(negedge clk);
            if (dp_pkt_in_avail) begin
                n_avail++;
                check("launch_pkt", 128'(dp_pkt_in), 128'(exp_pkt));
            end
            if (dp_re) begin
                run_len++;
                check("re_vs_encoder", 128'({dp_pkt_in_avail, dp_encoder_ready}), 128'(2'b01));
            end else if (run_len > 0) begin
                runs.push_back(run_len);
                run_len = 0;
            end
            if (done) begin
                n_done++;
                check("done_status", 128'(status), 128'(exp_status));
                check("done_req_ready", 128'(req_ready), 128'(0));
                if (exp_resp_valid) check("done_resp", 128'(resp_pkt), 128'(exp_resp));
            end
        end
    end

    task automatic drive_req(input logic [98:0] pkt, input logic exp_r);
        req_valid = 1'b1;
        req_pkt = pkt;
        req_expect_resp = exp_r;
        @(negedge clk);
        req_pkt = ~pkt;
        req_expect_resp = ~exp_r;
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run_xfer(input string name, input logic [98:0] pkt, input logic exp_r,
                            input int k0, input int d0, input int k1, input int d1,
                            input int k2, input int d2, input logic [98:0] rpkt,
                            input int lit_status, input int lit_tries);
        int st, tries, avail_base, done_base, runs_base, exp_len;
        model(exp_r, k0, k1, k2, st, tries);
        check({name, "_model_status"}, 128'(st), 128'(lit_status));
        check({name, "_model_tries"}, 128'(tries), 128'(lit_tries));
        plan_kind[0] = k0; plan_kind[1] = k1; plan_kind[2] = k2;
        plan_dly[0] = d0;  plan_dly[1] = d1;  plan_dly[2] = d2;
        plan_pkt = rpkt;
        plan_base = n_rx;
        exp_pkt = pkt;
        exp_status = st;
        exp_resp = rpkt;
        exp_resp_valid = exp_r && (st == 0);
        avail_base = n_avail; done_base = n_done; runs_base = runs.size();
        check({name, "_idle_ready"}, 128'(req_ready), 128'(1));
        drive_req(pkt, exp_r);
        for (int c = 0; c < 3000; c++) begin
            if (n_done > done_base) break;
            @(negedge clk);
            #1;
        end
        check({name, "_done_seen"}, 128'(n_done > done_base), 128'(1));
        @(negedge clk);
        #1;
        check({name, "_ready_after"}, 128'(req_ready), 128'(1));
        check({name, "_launches"}, 128'(n_avail - avail_base), 128'(tries));
        check({name, "_done_count"}, 128'(n_done - done_base), 128'(1));
        check({name, "_rx_windows"}, 128'(runs.size() - runs_base), 128'(exp_r ? tries : 0));
        for (int i = 0; i < tries && exp_r && (runs_base + i) < runs.size(); i++) begin
            exp_len = (plan_kind[i] == 0) ? TMO : plan_dly[i] + 1;
            check({name, "_rx_len"}, 128'(runs[runs_base + i]), 128'(exp_len));
        end
    endtask

    task automatic reset_mid_drain();
        int avail_base, done_base;
        plan_kind[0] = 2; plan_kind[1] = 2; plan_kind[2] = 2;
        plan_dly[0] = 1;  plan_dly[1] = 1;  plan_dly[2] = 1;
        plan_base = n_rx;
        exp_pkt = 99'h7777_0000_1234;
        exp_status = 0;
        exp_resp_valid = 1'b0;
        avail_base = n_avail; done_base = n_done;
        drive_req(exp_pkt, 1'b1);
        check("rst_mid_launched", 128'(n_avail - avail_base), 128'(1));
        check("rst_mid_in_drain", 128'(dp_encoder_ready), 128'(0));
        #1 rst_b = 1'b0;
        #1;
        check("rst_mid_req_ready", 128'(req_ready), 128'(1));
        check("rst_mid_done", 128'(done), 128'(0));
        check("rst_mid_status", 128'(status), 128'(0));
        check("rst_mid_resp", 128'(resp_pkt), 128'(0));
        check("rst_mid_pkt_in", 128'(dp_pkt_in), 128'(0));
        check("rst_mid_avail", 128'(dp_pkt_in_avail), 128'(0));
        check("rst_mid_re", 128'(dp_re), 128'(0));
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_mid_ready_after", 128'(req_ready), 128'(1));
        check("rst_mid_no_done", 128'(n_done - done_base), 128'(0));
    endtask

    initial begin
        rst_b = 1'b0;
        req_valid = 1'b0; req_pkt = '0; req_expect_resp = 1'b0;
        plan_kind[0] = 0; plan_kind[1] = 0; plan_kind[2] = 0;
        plan_dly[0] = 0;  plan_dly[1] = 0;  plan_dly[2] = 0;
        plan_pkt = '0; plan_base = 0;
        exp_pkt = '0; exp_resp = '0; exp_status = 0; exp_resp_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 128'(req_ready), 128'(1));
        check("rst_done", 128'(done), 128'(0));
        check("rst_status", 128'(status), 128'(0));
        check("rst_resp", 128'(resp_pkt), 128'(0));
        check("rst_pkt_in", 128'(dp_pkt_in), 128'(0));
        check("rst_avail", 128'(dp_pkt_in_avail), 128'(0));
        check("rst_re", 128'(dp_re), 128'(0));
        rst_b = 1'b1;
        repeat (2) @(negedge clk);

        run_xfer("no_resp",   99'h1_2345_6789_ABCD, 1'b0, 0, 0, 0, 0, 0, 0, 99'h0,   0, 1);
        run_xfer("good_resp", 99'h55AA,             1'b1, 2, 10, 0, 0, 0, 0, 99'h1A5, 0, 1);
        run_xfer("retry_ok",  99'h3C3C_0F0F,        1'b1, 1, 3, 1, 7, 2, 5, 99'h2C3, 0, 3);
        run_xfer("timeout",   99'hDEAD_BEEF,        1'b1, 0, 0, 0, 0, 0, 0, 99'h0,   1, 3);
        run_xfer("simul",     99'h4_0000_0001,      1'b1, 2, TMO - 1, 0, 0, 0, 0, 99'h3F1, 0, 1);
        run_xfer("crc_fail",  99'h6161,             1'b1, 1, 2, 1, 2, 1, 2, 99'h0,   2, 3);
        run_xfer("mixed_tmo", 99'h7E7E,             1'b1, 1, 4, 1, 0, 0, 0, 99'h0,   1, 3);
        reset_mid_drain();
        run_xfer("post_rst",  99'h0F0F_F0F0,        1'b1, 2, 0, 0, 0, 0, 0, 99'h5A,  0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
